// File: rtl/msrv32_pc_unit_if.sv
// Instruction-fetch PC interface: redirect requests in, PC / fetch address out.
interface msrv32_pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             ahb_ready_in;
  logic             branch_taken_in;
  logic [4:0]       opcode_6_to_2_in;
  logic [WIDTH-1:0] rs1_in;
  logic [WIDTH-1:0] imm_in;
  logic             trap_taken_in;
  logic             mret_in;
  logic [WIDTH-1:0] trap_addr_in;
  logic [WIDTH-1:0] epc_in;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_plus_4_out;
  logic [WIDTH-1:0] iaddr_out;
  logic             flush_out;
  logic             misaligned_instr_out;

  modport master (
    output ahb_ready_in, branch_taken_in, opcode_6_to_2_in, rs1_in, imm_in,
           trap_taken_in, mret_in, trap_addr_in, epc_in,
    input  pc_out, pc_plus_4_out, iaddr_out, flush_out, misaligned_instr_out
  );

  modport slave (
    input  ahb_ready_in, branch_taken_in, opcode_6_to_2_in, rs1_in, imm_in,
           trap_taken_in, mret_in, trap_addr_in, epc_in,
    output pc_out, pc_plus_4_out, iaddr_out, flush_out, misaligned_instr_out
  );
endinterface

// File: rtl/msrv32_pc_unit.sv
// Program-counter unit: architectural PC, next fetch address, redirect bubbles.
// Optional misaligned-target detection enabled by defining MSRV32_MISALIGN_CHECK_EN.
module msrv32_pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] BOOT_ADDR = '0
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  msrv32_pc_unit_if.slave  pc_bus
);

  localparam logic [4:0] OP_BR   = 5'b11000;
  localparam logic [4:0] OP_JAL  = 5'b11011;
  localparam logic [4:0] OP_JALR = 5'b11001;

  typedef enum logic {ST_BOOT, ST_RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_q, pc_nxt;
  logic             flush_q, flush_nxt;
  logic [WIDTH-1:0] seq_pc, tgt_raw, tgt, next_pc;
  logic             is_jump, is_jalr, redirect, bad_tgt;

  always_comb begin
    seq_pc   = pc_q + WIDTH'(4);
    is_jalr  = (pc_bus.opcode_6_to_2_in == OP_JALR);
    is_jump  = is_jalr || (pc_bus.opcode_6_to_2_in == OP_BR) ||
               (pc_bus.opcode_6_to_2_in == OP_JAL);
    redirect = pc_bus.branch_taken_in && is_jump;
    tgt_raw  = is_jalr ? ((pc_bus.rs1_in + pc_bus.imm_in) & {{(WIDTH-1){1'b1}}, 1'b0})
                       : (pc_q + pc_bus.imm_in);
`ifdef MSRV32_MISALIGN_CHECK_EN
    tgt      = tgt_raw;
    bad_tgt  = redirect && tgt[1];
`else
    // Without the check the low bits are dropped so a redirect always proceeds.
    tgt      = tgt_raw & {{(WIDTH-2){1'b1}}, 2'b00};
    bad_tgt  = 1'b0;
`endif
    if (pc_bus.trap_taken_in)      next_pc = pc_bus.trap_addr_in;
    else if (pc_bus.mret_in)       next_pc = pc_bus.epc_in;
    else if (redirect && !bad_tgt) next_pc = tgt;
    else                           next_pc = seq_pc;
  end

  always_comb begin
    state_nxt                   = state;
    pc_nxt                      = pc_q;
    flush_nxt                   = flush_q;
    pc_bus.iaddr_out            = BOOT_ADDR;
    pc_bus.misaligned_instr_out = 1'b0;
    case (state)
      ST_BOOT: begin
        if (pc_bus.ahb_ready_in) begin
          state_nxt = ST_RUN;
          pc_nxt    = BOOT_ADDR;
          flush_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        pc_bus.iaddr_out            = next_pc;
        pc_bus.misaligned_instr_out = bad_tgt && ms_riscv32_mp_rst_in;
        if (pc_bus.ahb_ready_in) begin
          pc_nxt    = next_pc;
          flush_nxt = (next_pc != seq_pc);
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state   <= ST_BOOT;
      pc_q    <= BOOT_ADDR;
      flush_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      flush_q <= flush_nxt;
    end
  end

  assign pc_bus.pc_out        = pc_q;
  assign pc_bus.pc_plus_4_out = seq_pc;
  assign pc_bus.flush_out     = flush_q;

endmodule

// File: tb/tb_msrv32_pc_unit.sv
// Self-checking bench for msrv32_pc_unit: directed vector table, stall/reset
// sequences, then randomized traffic against a behavioural PC model.
module tb_msrv32_pc_unit;

`ifdef MSRV32_MISALIGN_CHECK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  localparam logic [4:0] OP_BR   = 5'b11000;
  localparam logic [4:0] OP_JAL  = 5'b11011;
  localparam logic [4:0] OP_JALR = 5'b11001;
  localparam logic [4:0] OP_ALU  = 5'b01100;

  typedef struct {
    logic        rst_n, rdy, tk;
    logic [4:0]  op;
    logic [31:0] rs1, imm;
    logic        trap, mret;
    logic [31:0] taddr, epc;
    logic        chk_comb;
    logic [31:0] e_iaddr, e_pp4;
    logic        e_mis;
    logic [31:0] e_pc;
    logic        e_flush;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_total = 0;
  int   n_pass  = 0;

  msrv32_pc_unit_if #(.WIDTH(32)) bus ();

  msrv32_pc_unit #(.WIDTH(32), .BOOT_ADDR(32'h0000_0000)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .pc_bus               (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(
    input logic rs, input logic rdy, input logic tk, input logic [4:0] op,
    input logic [31:0] rs1, input logic [31:0] imm, input logic trap, input logic mret,
    input logic [31:0] taddr, input logic [31:0] epc, input logic cc,
    input logic [31:0] ei, input logic [31:0] ep4, input logic em,
    input logic [31:0] epc_o, input logic ef);
    vec_t v;
    v.rst_n = rs; v.rdy = rdy; v.tk = tk; v.op = op; v.rs1 = rs1; v.imm = imm;
    v.trap = trap; v.mret = mret; v.taddr = taddr; v.epc = epc; v.chk_comb = cc;
    v.e_iaddr = ei; v.e_pp4 = ep4; v.e_mis = em; v.e_pc = epc_o; v.e_flush = ef;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst_n                = v.rst_n;
    bus.ahb_ready_in     = v.rdy;
    bus.branch_taken_in  = v.tk;
    bus.opcode_6_to_2_in = v.op;
    bus.rs1_in           = v.rs1;
    bus.imm_in           = v.imm;
    bus.trap_taken_in    = v.trap;
    bus.mret_in          = v.mret;
    bus.trap_addr_in     = v.taddr;
    bus.epc_in           = v.epc;
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, ".mis"}, 32'(bus.misaligned_instr_out), 32'(v.e_mis));
    if (v.chk_comb) begin
      chk({tag, ".iaddr"}, bus.iaddr_out, v.e_iaddr);
      chk({tag, ".pc4"}, bus.pc_plus_4_out, v.e_pp4);
    end
    @(posedge clk);
    #1;
    chk({tag, ".pc"}, bus.pc_out, v.e_pc);
    chk({tag, ".flush"}, 32'(bus.flush_out), 32'(v.e_flush));
  endtask

  // Behavioural reference: architectural PC plus a "has booted" flag.
  bit          m_booted;
  logic [31:0] m_pc;
  logic        m_flush;

  function automatic logic [31:0] jump_target(input vec_t v, input logic [31:0] pc);
    logic [31:0] t;
    if (v.op == OP_JALR) t = (v.rs1 + v.imm) & 32'hFFFF_FFFE;
    else                 t = pc + v.imm;
    if (!EN) t = t & 32'hFFFF_FFFC;
    return t;
  endfunction

  function automatic bit wants_jump(input vec_t v);
    return v.tk && (v.op == OP_BR || v.op == OP_JAL || v.op == OP_JALR);
  endfunction

  function automatic bit bad_jump(input vec_t v, input logic [31:0] pc);
    logic [31:0] t;
    t = jump_target(v, pc);
    return EN && wants_jump(v) && (t % 4 >= 2);
  endfunction

  function automatic logic [31:0] model_next(input vec_t v, input logic [31:0] pc);
    if (v.trap) return v.taddr;
    if (v.mret) return v.epc;
    if (wants_jump(v) && !bad_jump(v, pc)) return jump_target(v, pc);
    return pc + 32'd4;
  endfunction

  vec_t tbl[$];

  initial begin
    vec_t v;
    logic [31:0] p11;
    drive(mk(0, 0, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    p11 = EN ? 32'h104 : 32'h2000;

    // rst, rdy, tk, op, rs1, imm, trap, mret, taddr, epc, cc, iaddr, pc4, mis, pc, flush
    tbl.push_back(mk(0, 1, 1, OP_JAL, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1));
    tbl.push_back(mk(0, 1, 0, OP_ALU, 0, 0, 1, 0, 32'h80, 0, 0, 0, 0, 0, 32'h0, 1));
    tbl.push_back(mk(1, 1, 1, OP_JAL, 0, 32'h6, 1, 0, 32'h80, 0, 1, 32'h0, 32'h4, 0, 32'h0, 0));
    tbl.push_back(mk(1, 1, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 1, 32'h4, 32'h4, 0, 32'h4, 0));
    tbl.push_back(mk(1, 1, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 1, 32'h8, 32'h8, 0, 32'h8, 0));
    tbl.push_back(mk(1, 1, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 1, 32'hC, 32'hC, 0, 32'hC, 0));
    tbl.push_back(mk(1, 1, 0, OP_ALU, 0, 0, 1, 0, 32'h100, 0, 1, 32'h100, 32'h10, 0, 32'h100, 1));
    tbl.push_back(mk(1, 1, 1, OP_BR, 0, 32'h20, 0, 0, 0, 0, 1, 32'h120, 32'h104, 0, 32'h120, 1));
    tbl.push_back(mk(1, 1, 0, OP_BR, 0, 32'h20, 0, 0, 0, 0, 1, 32'h124, 32'h124, 0, 32'h124, 0));
    tbl.push_back(mk(1, 1, 1, OP_BR, 0, 32'hFFFF_FFDC, 0, 0, 0, 0, 1, 32'h100, 32'h128, 0, 32'h100, 1));
    tbl.push_back(mk(1, 1, 1, OP_JALR, 32'h2003, 32'h1, 0, 0, 0, 0, 1, 32'h2004, 32'h104, 0, 32'h2004, 1));
    tbl.push_back(mk(1, 1, 0, OP_ALU, 0, 0, 1, 0, 32'h100, 0, 1, 32'h100, 32'h2008, 0, 32'h100, 1));
    tbl.push_back(mk(1, 1, 1, OP_JALR, 32'h2003, 32'h0, 0, 0, 0, 0, 1, p11, 32'h104, EN, p11, !EN));
    tbl.push_back(mk(1, 1, 1, OP_BR, 0, 32'h8, 1, 1, 32'h80, 32'h400, 1, 32'h80, p11 + 32'd4, 0, 32'h80, 1));
    tbl.push_back(mk(1, 1, 1, OP_JAL, 0, 32'h10, 0, 1, 32'h80, 32'h400, 1, 32'h400, 32'h84, 0, 32'h400, 1));
    tbl.push_back(mk(1, 1, 1, OP_ALU, 0, 32'h40, 0, 0, 0, 0, 1, 32'h404, 32'h404, 0, 32'h404, 0));
    tbl.push_back(mk(1, 1, 1, OP_JAL, 0, 32'h6, 0, 0, 0, 0, 1, 32'h408, 32'h408, EN, 32'h408, 0));
    tbl.push_back(mk(1, 1, 1, OP_JAL, 0, 32'h6, 1, 0, 32'h200, 0, 1, 32'h200, 32'h40C, EN, 32'h200, 1));
    tbl.push_back(mk(1, 1, 0, OP_ALU, 0, 0, 1, 0, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 32'h204, 0, 32'hFFFF_FFFC, 1));
    tbl.push_back(mk(1, 1, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 1, 1, OP_BR, 0, 32'hFFFF_FFF0, 0, 0, 0, 0, 1, 32'hFFFF_FFF0, 32'h4, 0, 32'hFFFF_FFF0, 1));
    tbl.push_back(mk(1, 1, 1, OP_JAL, 0, 32'h30, 0, 0, 0, 0, 1, 32'h20, 32'hFFFF_FFF4, 0, 32'h20, 1));
    tbl.push_back(mk(1, 1, 1, OP_JALR, 32'h3000, 32'h5, 0, 0, 0, 0, 1, 32'h3004, 32'h24, 0, 32'h3004, 1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Stall for three cycles while a branch redirect is pending.
    apply(mk(1, 1, 0, OP_ALU, 0, 0, 1, 0, 32'h300, 0, 1, 32'h300, 32'h3008, 0, 32'h300, 1), "stall_trap");
    apply(mk(1, 1, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 1, 32'h304, 32'h304, 0, 32'h304, 0), "stall_seq");
    for (int i = 0; i < 3; i++)
      apply(mk(1, 0, 1, OP_BR, 0, 32'h20, 0, 0, 0, 0, 1, 32'h324, 32'h308, 0, 32'h304, 0),
            $sformatf("stall%0d", i));
    apply(mk(1, 1, 1, OP_BR, 0, 32'h20, 0, 0, 0, 0, 1, 32'h324, 32'h308, 0, 32'h324, 1), "stall_go");
    apply(mk(1, 1, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 1, 32'h328, 32'h328, 0, 32'h328, 0), "stall_after");

    // Reset during a stall with a misaligned JALR pending, then boot held by ready=0.
    apply(mk(0, 0, 1, OP_JALR, 32'h2003, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1), "rst_stall");
    apply(mk(1, 0, 1, OP_JAL, 0, 32'h40, 0, 0, 0, 0, 1, 32'h0, 32'h4, 0, 32'h0, 1), "boot_hold");
    apply(mk(1, 1, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h4, 0, 32'h0, 0), "boot_go");
    apply(mk(1, 1, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 1, 32'h4, 32'h4, 0, 32'h4, 0), "boot_seq");
    apply(mk(0, 1, 0, OP_ALU, 0, 0, 1, 0, 32'h500, 0, 0, 0, 0, 0, 32'h0, 1), "rst_redir");
    apply(mk(1, 1, 0, OP_ALU, 0, 0, 1, 0, 32'h500, 0, 1, 32'h0, 32'h4, 0, 32'h0, 0), "boot_trap");

    // Randomized traffic checked against the behavioural model.
    m_booted = 1'b1;
    m_pc     = 32'h0;
    m_flush  = 1'b0;
    for (int c = 0; c < 500; c++) begin
      logic [31:0] nxt;
      logic [31:0] r;
      r          = $urandom;
      v.rst_n    = ($urandom_range(0, 39) != 0);
      v.rdy      = ($urandom_range(0, 3) != 0);
      v.tk       = r[0];
      case (r[2:1])
        2'd0: v.op = OP_BR;
        2'd1: v.op = OP_JAL;
        2'd2: v.op = OP_JALR;
        default: v.op = OP_ALU;
      endcase
      v.rs1      = $urandom;
      v.imm      = r[3] ? $urandom : {{22{r[4]}}, r[13:5], 1'b0};
      v.trap     = ($urandom_range(0, 9) == 0);
      v.mret     = ($urandom_range(0, 9) == 0);
      v.taddr    = $urandom & 32'hFFFF_FFFC;
      v.epc      = $urandom & 32'hFFFF_FFFC;
      nxt        = model_next(v, m_pc);
      @(negedge clk);
      drive(v);
      #1;
      chk($sformatf("rnd%0d.mis", c), 32'(bus.misaligned_instr_out),
          32'(v.rst_n && m_booted && bad_jump(v, m_pc)));
      if (v.rst_n) begin
        chk($sformatf("rnd%0d.iaddr", c), bus.iaddr_out, m_booted ? nxt : 32'h0);
        chk($sformatf("rnd%0d.pc4", c), bus.pc_plus_4_out, m_pc + 32'd4);
      end
      @(posedge clk);
      if (!v.rst_n) begin
        m_booted = 1'b0; m_pc = 32'h0; m_flush = 1'b1;
      end else if (v.rdy) begin
        if (!m_booted) begin
          m_booted = 1'b1; m_pc = 32'h0; m_flush = 1'b0;
        end else begin
          m_flush = (nxt != m_pc + 32'd4);
          m_pc    = nxt;
        end
      end
      #1;
      chk($sformatf("rnd%0d.pc", c), bus.pc_out, m_pc);
      chk($sformatf("rnd%0d.flush", c), 32'(bus.flush_out), 32'(m_flush));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
